sw_debounce: RTL and testbench



---
 rtl/sw_debounce_if.sv | 23 ++
 rtl/sw_debounce.sv | 105 ++++++++++
 tb/tb_sw_debounce.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sw_debounce_if.sv
// Switch-conditioning bus: raw pins in, debounced vector, edge strobes and status out.
// sw_valid is a level, not a handshake: once high it stays high until reset, and strobes are only meaningful while it is high.
interface sw_debounce_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_export;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;
    logic             sw_valid;
    logic             fsm_state;

    modport master (
        output sw_raw,
        input  sw_export, sw_rise, sw_fall, sw_changed, sw_valid, fsm_state
    );

    modport slave (
        input  sw_raw,
        output sw_export, sw_rise, sw_fall, sw_changed, sw_valid, fsm_state
    );
endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-channel counting debouncer for slide switches.
// Edge strobes are held off during the post-reset qualification window (INIT).
module sw_debounce #(
    parameter int WIDTH         = 10,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic         clk_clk,
    input  logic         reset_reset,
    sw_debounce_if.slave sw
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int GW = $clog2(STABLE_CYCLES + 4);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [GW-1:0] INIT_LAST = GW'(STABLE_CYCLES + 2);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    logic [GW-1:0]    gcnt;
    logic             valid;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_next;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    // A channel flips only when it has disagreed for STABLE_CYCLES consecutive samples.
    always_comb begin
        stable_next = stable;
        for (int i = 0; i < WIDTH; i++) begin
            if ((s2[i] != stable[i]) && (cnt[i] == CNT_LAST)) begin
                stable_next[i] = s2[i];
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= INIT;
            gcnt  <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    gcnt <= gcnt + GW'(1);
                    if (gcnt == INIT_LAST) begin
                        state <= RUN;
                        valid <= 1'b1;
                    end
                end
                RUN: begin
                    valid <= 1'b1;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            s1      <= '0;
            s2      <= '0;
            stable  <= '0;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1     <= sw.sw_raw;
            s2     <= s1;
            stable <= stable_next;
            for (int i = 0; i < WIDTH; i++) begin
                if ((s2[i] == stable[i]) || (cnt[i] == CNT_LAST)) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            // Strobes share the edge of the stable update, gated by the pre-edge state.
            if (state == RUN) begin
                rise    <= stable_next & ~stable;
                fall    <= ~stable_next & stable;
                changed <= |(stable_next ^ stable);
            end else begin
                rise    <= '0;
                fall    <= '0;
                changed <= 1'b0;
            end
        end
    end

    assign sw.sw_export  = stable;
    assign sw.sw_rise    = rise;
    assign sw.sw_fall    = fall;
    assign sw.sw_changed = changed;
    assign sw.sw_valid   = valid;
    assign sw.fsm_state  = state;
endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES=4; every edge is checked against hand-computed values.
module tb_sw_debounce;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    sw_debounce_if #(.WIDTH(10)) sw_if ();

    sw_debounce #(
        .WIDTH        (10),
        .STABLE_CYCLES(4)
    ) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .sw         (sw_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Advance one edge, then compare every output.
    task automatic step_chk(input logic [9:0] e_exp, input logic [9:0] e_rise,
                            input logic [9:0] e_fall, input logic e_valid);
        @(posedge clk);
        #1;
        chk("export",  {22'd0, sw_if.sw_export}, {22'd0, e_exp});
        chk("rise",    {22'd0, sw_if.sw_rise},   {22'd0, e_rise});
        chk("fall",    {22'd0, sw_if.sw_fall},   {22'd0, e_fall});
        chk("changed", {31'd0, sw_if.sw_changed}, {31'd0, |(e_rise | e_fall)});
        chk("valid",   {31'd0, sw_if.sw_valid},  {31'd0, e_valid});
    endtask

    logic [9:0] e;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        sw_if.sw_raw = 10'h155;

        // Reset with pins held; edge 0 is the last edge with reset high.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_export", {22'd0, sw_if.sw_export}, 32'd0);
        chk("rst_valid",  {31'd0, sw_if.sw_valid},  32'd0);
        chk("rst_strobe", {21'd0, sw_if.sw_changed, sw_if.sw_rise | sw_if.sw_fall}, 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step_chk((k >= 6) ? 10'h155 : 10'h000, 10'h000, 10'h000, k >= 7);
        end

        // Clean rise on bit 3.
        e = 10'h155;
        sw_if.sw_raw = 10'h15D;
        for (int j = 0; j < 8; j++) begin
            step_chk((j >= 5) ? 10'h15D : e, (j == 5) ? 10'h008 : 10'h000, 10'h000, 1'b1);
        end
        e = 10'h15D;

        // Clear bit 0 so the pulse tests start from a low level.
        sw_if.sw_raw = 10'h15C;
        for (int j = 0; j < 8; j++) begin
            step_chk((j >= 5) ? 10'h15C : e, 10'h000, (j == 5) ? 10'h001 : 10'h000, 1'b1);
        end
        e = 10'h15C;

        // Three-cycle pulse on bit 0 is rejected.
        sw_if.sw_raw = 10'h15D;
        for (int j = 0; j < 3; j++) step_chk(e, 10'h000, 10'h000, 1'b1);
        sw_if.sw_raw = 10'h15C;
        for (int j = 3; j < 11; j++) step_chk(e, 10'h000, 10'h000, 1'b1);

        // Four-cycle pulse is accepted: rise at k+5, fall at k+9.
        sw_if.sw_raw = 10'h15D;
        for (int j = 0; j < 4; j++) step_chk(e, 10'h000, 10'h000, 1'b1);
        sw_if.sw_raw = 10'h15C;
        step_chk(e, 10'h000, 10'h000, 1'b1);
        step_chk(10'h15D, 10'h001, 10'h000, 1'b1);
        for (int j = 6; j < 9; j++) step_chk(10'h15D, 10'h000, 10'h000, 1'b1);
        step_chk(e, 10'h000, 10'h001, 1'b1);
        for (int j = 10; j < 13; j++) step_chk(e, 10'h000, 10'h000, 1'b1);

        // Bounce on bit 5: 1,1,1,0 for 40 cycles, then held high.
        for (int j = 0; j < 40; j++) begin
            sw_if.sw_raw = ((j % 4) == 3) ? 10'h15C : 10'h17C;
            step_chk(e, 10'h000, 10'h000, 1'b1);
        end
        sw_if.sw_raw = 10'h17C;
        for (int j = 0; j < 8; j++) begin
            step_chk((j >= 5) ? 10'h17C : e, (j == 5) ? 10'h020 : 10'h000, 10'h000, 1'b1);
        end
        e = 10'h17C;

        // Raise bit 1, then bit 9 rises and bit 1 falls together.
        sw_if.sw_raw = 10'h17E;
        for (int j = 0; j < 7; j++) begin
            step_chk((j >= 5) ? 10'h17E : e, (j == 5) ? 10'h002 : 10'h000, 10'h000, 1'b1);
        end
        e = 10'h17E;
        sw_if.sw_raw = 10'h37C;
        for (int j = 0; j < 8; j++) begin
            step_chk((j >= 5) ? 10'h37C : e, (j == 5) ? 10'h200 : 10'h000,
                     (j == 5) ? 10'h002 : 10'h000, 1'b1);
        end
        e = 10'h37C;

        // Reset two counts into a bit-7 qualification.
        sw_if.sw_raw = 10'h3FC;
        for (int j = 0; j < 4; j++) step_chk(e, 10'h000, 10'h000, 1'b1);
        rst = 1'b1;
        step_chk(10'h000, 10'h000, 10'h000, 1'b0);
        chk("rst_state", {31'd0, sw_if.fsm_state}, 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step_chk((k >= 6) ? 10'h3FC : 10'h000, 10'h000, 10'h000, k >= 7);
        end
        chk("run_state", {31'd0, sw_if.fsm_state}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
